// File: rtl/baud_tick_generator_if.sv
// Strobe bus between the baud-rate generator and the UART transmitter/receiver.
// The controller side (master) drives enable, rate select and resync. The
// generator side (slave) returns the three one-cycle strobes.
interface baud_tick_generator_if;
  logic       enable;
  logic [2:0] baud_select;
  logic       resync;
  logic       sample_ENABLE;
  logic       bit_ENABLE;
  logic       mid_ENABLE;

  modport master (
    output enable, baud_select, resync,
    input  sample_ENABLE, bit_ENABLE, mid_ENABLE
  );

  modport slave (
    input  enable, baud_select, resync,
    output sample_ENABLE, bit_ENABLE, mid_ENABLE
  );
endinterface

// File: rtl/baud_tick_generator.sv
// Baud-rate tick generator: oversampling, bit-rate and mid-bit strobes.
// The rate table (divisors, or phase increments) is built at elaboration from
// CLK_HZ and OVERSAMPLE, so no division happens at run time.
// Optional feature macro BAUD_FRAC_EN: when it is defined, the integer divider
// is replaced by an ACC_W-bit phase accumulator whose carry-out is the sample
// tick. When it is undefined, ACC_W is unused.
// Strobes are registered. Each one rises at the clock edge where the divider
// wraps, so the first sample strobe arrives D edges after the edge that
// cleared the phase.
module baud_tick_generator #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  baud_tick_generator_if.slave tick_if
);

  localparam int unsigned     SC_W    = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 32'd1);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 32'd2 - 32'd1);

  function automatic longint unsigned baud_of(input int unsigned sel);
    case (sel)
      32'd0:   return 64'd300;
      32'd1:   return 64'd1200;
      32'd2:   return 64'd4800;
      32'd3:   return 64'd9600;
      32'd4:   return 64'd19200;
      32'd5:   return 64'd38400;
      32'd6:   return 64'd57600;
      default: return 64'd115200;
    endcase
  endfunction

  // Rounded integer divisor: round(CLK_HZ / (OVERSAMPLE * baud)).
  function automatic longint unsigned div_of(input int unsigned sel);
    longint unsigned den;
    den = 64'(OVERSAMPLE) * baud_of(sel);
    return (64'(CLK_HZ) + den / 64'd2) / den;
  endfunction

  function automatic logic [8*DIV_W-1:0] build_div_tbl();
    logic [8*DIV_W-1:0] tbl;
    longint unsigned    d;
    tbl = '0;
    for (int unsigned s = 32'd0; s < 32'd8; s++) begin
      d = div_of(s);
      tbl[s*DIV_W +: DIV_W] = d[DIV_W-1:0];
    end
    return tbl;
  endfunction

  localparam longint unsigned DIV_SLOWEST = div_of(32'd0);

  // Reject configurations the counters cannot represent.
  generate
    if ((DIV_SLOWEST >= (64'd1 << DIV_W)) || ((OVERSAMPLE % 32'd2) != 32'd0) ||
        (OVERSAMPLE < 32'd4) || (ACC_W == 32'd0)) begin : g_bad_cfg
      $error("baud_tick_generator: unsupported CLK_HZ/OVERSAMPLE/DIV_W/ACC_W");
    end
  endgenerate

`ifdef BAUD_FRAC_EN
  // Rounded phase increment: round(OVERSAMPLE * baud * 2^ACC_W / CLK_HZ).
  function automatic longint unsigned inc_of(input int unsigned sel);
    longint unsigned num;
    num = (64'(OVERSAMPLE) * baud_of(sel)) << ACC_W;
    return (num + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ);
  endfunction

  function automatic logic [8*ACC_W-1:0] build_inc_tbl();
    logic [8*ACC_W-1:0] tbl;
    longint unsigned    d;
    tbl = '0;
    for (int unsigned s = 32'd0; s < 32'd8; s++) begin
      d = inc_of(s);
      tbl[s*ACC_W +: ACC_W] = d[ACC_W-1:0];
    end
    return tbl;
  endfunction

  localparam logic [8*ACC_W-1:0] INC_TBL = build_inc_tbl();
  logic [ACC_W-1:0] acc_q, acc_d, inc_s;
`else
  localparam logic [8*DIV_W-1:0] DIV_TBL = build_div_tbl();
  logic [DIV_W-1:0] div_q, div_d, div_last_s;
`endif

  logic [2:0]      sel_q;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            sample_q, sample_d;
  logic            bit_q, bit_d;
  logic            mid_q, mid_d;
  logic            clear_s;
  logic            tick_s;

  // Phase divider: advance by one period step and flag the wrap (tick) cycle.
  always_comb begin
`ifdef BAUD_FRAC_EN
    inc_s           = INC_TBL[32'(sel_q) * ACC_W +: ACC_W];
    {tick_s, acc_d} = {1'b0, acc_q} + {1'b0, inc_s};
`else
    div_last_s = DIV_TBL[32'(sel_q) * DIV_W +: DIV_W] - DIV_W'(1);
    tick_s     = (div_q == div_last_s);
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
`endif
  end

  // Sample counter and strobe decode. Disable, a rate change or a resync clears
  // the phase and wins over any strobe that would have fired this cycle.
  always_comb begin
    sc_d     = sc_q;
    sample_d = 1'b0;
    bit_d    = 1'b0;
    mid_d    = 1'b0;
    clear_s  = !tick_if.enable || (tick_if.baud_select != sel_q) || tick_if.resync;
    if (clear_s) begin
      sc_d = '0;
    end else if (tick_s) begin
      sample_d = 1'b1;
      bit_d    = (sc_q == SC_LAST);
      mid_d    = (sc_q == SC_MID);
      if (sc_q == SC_LAST) begin
        sc_d = '0;
      end else begin
        sc_d = sc_q + SC_W'(1);
      end
    end else begin
      sc_d = sc_q;
    end
  end

  // State and strobe registers. Reset is immediate, even in the middle of a bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 3'd0;
      sc_q     <= '0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      mid_q    <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q    <= '0;
`else
      div_q    <= '0;
`endif
    end else begin
      sel_q    <= tick_if.baud_select;
      sc_q     <= sc_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      mid_q    <= mid_d;
`ifdef BAUD_FRAC_EN
      if (clear_s) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
`else
      if (clear_s) begin
        div_q <= '0;
      end else begin
        div_q <= div_d;
      end
`endif
    end
  end

  assign tick_if.sample_ENABLE = sample_q;
  assign tick_if.bit_ENABLE    = bit_q;
  assign tick_if.mid_ENABLE    = mid_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator.
// Reference model: each clear event (reset, enable low, rate change, resync)
// records the edge index t0. The number of sample ticks after n = edge - t0
// edges is n / D (integer mode) or floor(n * INC / 2^ACC_W) (BAUD_FRAC_EN).
// A strobe fires whenever that count steps. The k-th strobe is a bit strobe
// when k % OVERSAMPLE == 0, and a mid strobe when k % OVERSAMPLE == OVERSAMPLE/2.
module tb_baud_tick_generator;
  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned OS     = 16;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned ACC_W  = 24;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  baud_tick_generator_if tick_if();

  baud_tick_generator #(
    .CLK_HZ(CLK_HZ), .OVERSAMPLE(OS), .DIV_W(DIV_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .tick_if(tick_if)
  );

  int         n_cmp    = 0;
  int         n_mis    = 0;
  longint     edge_cnt = 0;
  longint     t0       = 0;
  longint     mdl_n, mdl_k;
  logic [2:0] selm     = 3'd0;
  logic       exp_s    = 1'b0;
  logic       exp_b    = 1'b0;
  logic       exp_m    = 1'b0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic real baud_hz(input int s);
    case (s)
      0:       return 300.0;
      1:       return 1200.0;
      2:       return 4800.0;
      3:       return 9600.0;
      4:       return 19200.0;
      5:       return 38400.0;
      6:       return 57600.0;
      default: return 115200.0;
    endcase
  endfunction

  function automatic longint period_cycles(input int s);
    return longint'($rtoi(real'(CLK_HZ) / (real'(OS) * baud_hz(s)) + 0.5));
  endfunction

`ifdef BAUD_FRAC_EN
  function automatic longint phase_inc(input int s);
    return longint'($rtoi(real'(OS) * baud_hz(s) * (2.0 ** ACC_W) / real'(CLK_HZ) + 0.5));
  endfunction

  function automatic longint ticks_after(input longint n, input int s);
    return (n * phase_inc(s)) >> ACC_W;
  endfunction
`else
  function automatic longint ticks_after(input longint n, input int s);
    return n / period_cycles(s);
  endfunction
`endif

  // Reference model: evaluate the expected strobes produced by each clock edge.
  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (!reset) begin
      t0 = edge_cnt; selm = 3'd0;
      exp_s = 1'b0; exp_b = 1'b0; exp_m = 1'b0;
    end else begin
      if (!tick_if.enable || (tick_if.baud_select != selm) || tick_if.resync) begin
        t0 = edge_cnt;
        exp_s = 1'b0; exp_b = 1'b0; exp_m = 1'b0;
      end else begin
        mdl_n = edge_cnt - t0;
        mdl_k = ticks_after(mdl_n, int'(selm));
        exp_s = (mdl_k != ticks_after(mdl_n - 1, int'(selm)));
        exp_b = exp_s && ((mdl_k % OS) == 0);
        exp_m = exp_s && ((mdl_k % OS) == OS / 2);
      end
      selm = tick_if.baud_select;
    end
  end

  // Every cycle: compare the DUT strobes with the model, away from the active edge.
  always @(negedge clk) begin
    check_eq("sample", tick_if.sample_ENABLE, exp_s);
    check_eq("bit", tick_if.bit_ENABLE, exp_b);
    check_eq("mid", tick_if.mid_ENABLE, exp_m);
  end

  // Wait a bounded number of cycles for one strobe; which: 0=sample 1=bit 2=mid.
  task automatic wait_strobe(input string tag, input int which, input int budget,
                             output longint at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      case (which)
        0:       found = tick_if.sample_ENABLE;
        1:       found = tick_if.bit_ENABLE;
        2:       found = tick_if.mid_ENABLE;
        default: found = 1'b0;
      endcase
      if (found) at = edge_cnt;
    end
    check_eq({tag, "_seen"}, longint'(found), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e1, e2, eb, em, re, c, s, e0, d7;
    int     cnt, en_hold;
    d7 = period_cycles(7);
    tick_if.enable = 1'b0; tick_if.baud_select = 3'd0; tick_if.resync = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", {tick_if.sample_ENABLE, tick_if.bit_ENABLE, tick_if.mid_ENABLE}, 0);
    #1 reset = 1'b1; tick_if.enable = 1'b1; tick_if.baud_select = 3'b111;

`ifdef BAUD_FRAC_EN
    // Fractional rate at 115200: long-run count within one strobe, spacing 54 or 55.
    @(negedge clk); #1 tick_if.resync = 1'b1; re = edge_cnt + 1;
    @(negedge clk); #1 tick_if.resync = 1'b0;
    cnt = 0; e1 = re;
    repeat (50000) begin
      @(negedge clk);
      if (tick_if.sample_ENABLE) begin
        check_eq("frac_gap_ok", longint'((edge_cnt - e1 == 54) || (edge_cnt - e1 == 55)), 1);
        e1 = edge_cnt; cnt++;
      end
    end
    check_eq("frac_count_ok", longint'(((real'(cnt) - real'(edge_cnt - re) * real'(OS) *
             115200.0 / real'(CLK_HZ)) <= 1.0) && ((real'(edge_cnt - re) * real'(OS) *
             115200.0 / real'(CLK_HZ) - real'(cnt)) <= 1.0)), 1);
`else
    // Steady state at 115200: sample, bit and mid spacing.
    wait_strobe("smp_a", 0, 200, e1);
    wait_strobe("smp_b", 0, 200, e2);
    check_eq("smp_gap", e2 - e1, d7);
    wait_strobe("bit_a", 1, 2000, eb);
    wait_strobe("mid_a", 2, 1000, em);
    check_eq("mid_after_bit", em - eb, (OS / 2) * d7);
    wait_strobe("bit_b", 1, 1000, e2);
    check_eq("bit_gap", e2 - eb, OS * d7);

    // Resync at 9600: first mid and bit strobes measured from the clearing edge.
    @(negedge clk); #1 tick_if.baud_select = 3'b011;
    repeat (100) @(negedge clk);
    #1 tick_if.resync = 1'b1; re = edge_cnt + 1;
    @(negedge clk); #1 tick_if.resync = 1'b0;
    wait_strobe("rs_mid", 2, 6000, em);
    check_eq("rs_first_mid", em - re, (OS / 2) * period_cycles(3));
    wait_strobe("rs_bit", 1, 6000, eb);
    check_eq("rs_first_bit", eb - re, OS * period_cycles(3));

    // Rate change mid-bit: one quiet cycle, then a full new period.
    repeat (300) @(negedge clk);
    #1 tick_if.baud_select = 3'b111; c = edge_cnt + 1;
    @(negedge clk);
    check_eq("chg_quiet", {tick_if.sample_ENABLE, tick_if.bit_ENABLE, tick_if.mid_ENABLE}, 0);
    wait_strobe("chg_smp", 0, 200, s);
    check_eq("chg_first_smp", s - c, d7);

    // Resync landing exactly on a would-be strobe suppresses it.
    wait_strobe("pre_rs", 0, 200, s);
    repeat (int'(d7) - 1) @(negedge clk);
    #1 tick_if.resync = 1'b1;
    @(negedge clk);
    check_eq("rs_suppress", tick_if.sample_ENABLE, 0);
    #1 tick_if.resync = 1'b0;
    wait_strobe("post_rs", 0, 200, e1);
    check_eq("rs_next_smp", e1 - (s + d7), d7);

    // Reset in the middle of a strobe cycle, then a full period after release.
    wait_strobe("pre_rst", 0, 200, s);
    #1 reset = 1'b0; tick_if.baud_select = 3'b000;
    #1 check_eq("rst_async", tick_if.sample_ENABLE, 0);
    repeat (5) @(negedge clk);
    e0 = edge_cnt;
    #1 reset = 1'b1;
    wait_strobe("post_rst", 0, int'(period_cycles(0)) + 100, e1);
    check_eq("rst_first_smp", e1 - e0, period_cycles(0));
    #1 tick_if.baud_select = 3'b111;
`endif

    // Enable low: silent for 10000 cycles, then counting restarts from zero.
    #1 tick_if.enable = 1'b0;
    cnt = 0;
    repeat (10000) begin
      @(negedge clk);
      cnt += int'(tick_if.sample_ENABLE) + int'(tick_if.bit_ENABLE) + int'(tick_if.mid_ENABLE);
    end
    check_eq("en_low_quiet", cnt, 0);
    e0 = edge_cnt;
    #1 tick_if.enable = 1'b1;
    wait_strobe("en_rise", 0, 200, e1);
    check_eq("en_first_smp", e1 - e0, ticks_after(e1 - e0, 7) > 0 ? e1 - e0 : -1);
`ifndef BAUD_FRAC_EN
    check_eq("en_first_smp_d", e1 - e0, d7);
`endif

    // Random traffic: rate changes, resync pulses and enable drops against the model.
    en_hold = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #1;
      tick_if.resync = ($urandom_range(0, 299) == 0);
      if (en_hold > 0) begin
        en_hold--;
        tick_if.enable = (en_hold == 0);
      end else if ($urandom_range(0, 999) == 0) begin
        tick_if.enable = 1'b0;
        en_hold = int'($urandom_range(1, 50));
      end
      if ($urandom_range(0, 499) == 0) begin
        if ($urandom_range(0, 7) == 0) tick_if.baud_select = 3'($urandom_range(0, 7));
        else tick_if.baud_select = 3'($urandom_range(4, 7));
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
